// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_pkg
//  Purpose  : Shared AXI4-Lite response encodings and a byte-lane merge
//             helper used by the scratchpad slave.
//  Contents : RESP_* response codes, BUS_DW / BUS_SW bus widths,
//             apply_wstrb() byte-enable merge function.
//  Revision : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int BUS_DW = 32;
    localparam int BUS_SW = BUS_DW / 8;

    // Replace each byte lane of old_word whose strobe bit is set with the
    // corresponding lane of new_word.
    function automatic logic [BUS_DW-1:0] apply_wstrb(
        input logic [BUS_DW-1:0] old_word,
        input logic [BUS_DW-1:0] new_word,
        input logic [BUS_SW-1:0] strb
    );
        logic [BUS_DW-1:0] result;
        result = old_word;
        for (int b = 0; b < BUS_SW; b++) begin
            if (strb[b]) begin
                result[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_skid_buffer
//  Purpose  : One-entry registered holding buffer with valid/ready on both
//             sides. Accepts a new entry only while empty, so its input
//             ready never depends on the consumer's ready.
//  Ports    : clk, rst_n        - clock, asynchronous active-low reset
//             i_valid/o_ready   - producer side handshake
//             i_data            - payload captured on producer handshake
//             o_valid/o_data    - held entry presented to the consumer
//             i_ready           - consumer pops the entry when high
//  Revision : 1.0 - initial release
// ============================================================================
module axi_lite_skid_buffer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_ready
);

    logic              r_full;
    logic [DATA_W-1:0] r_data;

    // Load and pop are mutually exclusive: loading needs the buffer empty,
    // popping needs it full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_valid && !r_full) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (r_full && i_ready) begin
            r_full <= 1'b0;
        end
    end

    assign o_ready = !r_full;
    assign o_valid = r_full;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/axi_lite_scratchpad.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_scratchpad
//  Purpose  : AXI4-Lite slave fronting a small byte-enabled register-file
//             memory. Every address decodes (upper bits select the word,
//             addr[1:0] ignored) and every response is OKAY.
//  Ports    : clk, rst_n             - clock, asynchronous active-low reset
//             i_axi_aw*/o_axi_awready - write address channel
//             i_axi_w*/o_axi_wready   - write data channel
//             o_axi_b*/i_axi_bready   - write response channel
//             i_axi_ar*/o_axi_arready - read address channel
//             o_axi_r*/i_axi_rready   - read data channel
//  Revision : 1.0 - initial release
// ============================================================================
module axi_lite_scratchpad
    import axi_lite_pkg::*;
#(
    parameter int MEMORY_BW_p    = 32,
    parameter int MEMORY_DEPTH_p = 4,
    localparam int AW            = $clog2((MEMORY_BW_p/8)*MEMORY_DEPTH_p)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] i_axi_awaddr,
    input  logic          i_axi_awvalid,
    output logic          o_axi_awready,
    input  logic [31:0]   i_axi_wdata,
    input  logic [3:0]    i_axi_wstrb,
    input  logic          i_axi_wvalid,
    output logic          o_axi_wready,
    output logic [1:0]    o_axi_bresp,
    output logic          o_axi_bvalid,
    input  logic          i_axi_bready,
    input  logic [AW-1:0] i_axi_araddr,
    input  logic          i_axi_arvalid,
    output logic          o_axi_arready,
    output logic [31:0]   o_axi_rdata,
    output logic [1:0]    o_axi_rresp,
    output logic          o_axi_rvalid,
    input  logic          i_axi_rready
);

    localparam int IDX_W = AW - 2;

    logic [31:0]      r_mem [MEMORY_DEPTH_p];

    // ------------------------------------------------------------------
    // Write path: AW and W are each parked in a one-entry hold; the word
    // is written once both are present and the B slot is free or draining.
    // ------------------------------------------------------------------
    logic             w_aw_held;
    logic [IDX_W-1:0] w_aw_idx;
    logic             w_w_held;
    logic [35:0]      w_w_payload;
    logic             w_commit;
    logic             r_bvalid;

    assign w_commit = w_aw_held && w_w_held && (!r_bvalid || i_axi_bready);

    axi_lite_skid_buffer #(.DATA_W(IDX_W)) u_aw_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_axi_awvalid),
        .o_ready (o_axi_awready),
        .i_data  (i_axi_awaddr[AW-1:2]),
        .o_valid (w_aw_held),
        .o_data  (w_aw_idx),
        .i_ready (w_commit)
    );

    axi_lite_skid_buffer #(.DATA_W(36)) u_w_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_axi_wvalid),
        .o_ready (o_axi_wready),
        .i_data  ({i_axi_wstrb, i_axi_wdata}),
        .o_valid (w_w_held),
        .o_data  (w_w_payload),
        .i_ready (w_commit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bvalid <= 1'b0;
        end else if (w_commit) begin
            r_bvalid <= 1'b1;
        end else if (i_axi_bready) begin
            r_bvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEMORY_DEPTH_p; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            r_mem[w_aw_idx] <= apply_wstrb(r_mem[w_aw_idx], w_w_payload[31:0],
                                           w_w_payload[35:32]);
        end
    end

    assign o_axi_bvalid = r_bvalid;
    assign o_axi_bresp  = RESP_OKAY;

    // ------------------------------------------------------------------
    // Read path: R output register backed by a one-entry skid. The memory
    // word is sampled on the AR handshake, so a same-edge write is not seen.
    // ------------------------------------------------------------------
    logic        w_ar_fire;
    logic        w_r_fire;
    logic        w_r_open;
    logic [31:0] w_rd_word;
    logic        w_skid_full;
    logic [31:0] w_skid_data;
    logic        r_rvalid;
    logic [31:0] r_rdata;

    assign w_ar_fire = i_axi_arvalid && o_axi_arready;
    assign w_r_fire  = r_rvalid && i_axi_rready;
    assign w_r_open  = !r_rvalid || i_axi_rready;
    assign w_rd_word = r_mem[i_axi_araddr[AW-1:2]];

    // The skid only captures when R is occupied and stalled; it is popped
    // into R on the next R handshake. Its ready doubles as arready.
    axi_lite_skid_buffer #(.DATA_W(32)) u_r_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_ar_fire && !w_r_open),
        .o_ready (o_axi_arready),
        .i_data  (w_rd_word),
        .o_valid (w_skid_full),
        .o_data  (w_skid_data),
        .i_ready (i_axi_rready)
    );

    // While the skid is full arready is low, so an AR handshake and a skid
    // transfer never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (w_ar_fire && w_r_open) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_word;
        end else if (w_r_fire && w_skid_full) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_skid_data;
        end else if (w_r_fire) begin
            r_rvalid <= 1'b0;
        end
    end

    assign o_axi_rvalid = r_rvalid;
    assign o_axi_rdata  = r_rdata;
    assign o_axi_rresp  = RESP_OKAY;

    // Byte-offset bits carry no meaning for a word-organised memory.
    logic w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = ^{i_axi_awaddr[1:0], i_axi_araddr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_scratchpad.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_lite_scratchpad
//  Purpose  : Self-checking bench for axi_lite_scratchpad. A transaction-level
//             model (word array, read-data queue, pending-write flags) is
//             compared with the DUT every cycle; directed sequences add
//             hand-computed literal checks; a randomized phase follows.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_scratchpad;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] i_axi_awaddr;
    logic          i_axi_awvalid;
    logic          o_axi_awready;
    logic [31:0]   i_axi_wdata;
    logic [3:0]    i_axi_wstrb;
    logic          i_axi_wvalid;
    logic          o_axi_wready;
    logic [1:0]    o_axi_bresp;
    logic          o_axi_bvalid;
    logic          i_axi_bready;
    logic [AW-1:0] i_axi_araddr;
    logic          i_axi_arvalid;
    logic          o_axi_arready;
    logic [31:0]   o_axi_rdata;
    logic [1:0]    o_axi_rresp;
    logic          o_axi_rvalid;
    logic          i_axi_rready;

    axi_lite_scratchpad #(
        .MEMORY_BW_p    (32),
        .MEMORY_DEPTH_p (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_axi_awaddr  (i_axi_awaddr),
        .i_axi_awvalid (i_axi_awvalid),
        .o_axi_awready (o_axi_awready),
        .i_axi_wdata   (i_axi_wdata),
        .i_axi_wstrb   (i_axi_wstrb),
        .i_axi_wvalid  (i_axi_wvalid),
        .o_axi_wready  (o_axi_wready),
        .o_axi_bresp   (o_axi_bresp),
        .o_axi_bvalid  (o_axi_bvalid),
        .i_axi_bready  (i_axi_bready),
        .i_axi_araddr  (i_axi_araddr),
        .i_axi_arvalid (i_axi_arvalid),
        .o_axi_arready (o_axi_arready),
        .o_axi_rdata   (o_axi_rdata),
        .o_axi_rresp   (o_axi_rresp),
        .o_axi_rvalid  (o_axi_rvalid),
        .i_axi_rready  (i_axi_rready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model.
    //   m_mem    : word contents
    //   m_rq     : read data accepted but not yet returned, oldest first
    //              (at most two may be outstanding)
    //   m_aw_p   : an accepted write address waiting for its data
    //   m_w_p    : accepted write data waiting for its address
    //   m_b      : a write response is being presented
    // ------------------------------------------------------------------
    logic [31:0] m_mem [4];
    logic [31:0] m_rq [$];
    bit          m_aw_p, m_w_p, m_b;
    logic [1:0]  m_aw_idx;
    logic [31:0] m_wd;
    logic [3:0]  m_ws;
    bit          aw_took, w_took, ar_took;

    bit          mdl_ar_rdy, mdl_aw_rdy, mdl_w_rdy, mdl_commit;
    logic [31:0] mdl_rd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_mem[i] = '0;
            m_rq.delete();
            m_aw_p  = 1'b0;
            m_w_p   = 1'b0;
            m_b     = 1'b0;
            aw_took = 1'b1;
            w_took  = 1'b1;
            ar_took = 1'b1;
        end else begin
            mdl_ar_rdy = (m_rq.size() < 2);
            mdl_aw_rdy = !m_aw_p;
            mdl_w_rdy  = !m_w_p;
            mdl_rd     = m_mem[i_axi_araddr[3:2]];
            mdl_commit = m_aw_p && m_w_p && (!m_b || i_axi_bready);
            aw_took    = i_axi_awvalid && mdl_aw_rdy;
            w_took     = i_axi_wvalid && mdl_w_rdy;
            ar_took    = i_axi_arvalid && mdl_ar_rdy;
            if (m_rq.size() > 0 && i_axi_rready) void'(m_rq.pop_front());
            if (ar_took) m_rq.push_back(mdl_rd);
            if (mdl_commit) begin
                for (int b = 0; b < 4; b++)
                    if (m_ws[b]) m_mem[m_aw_idx][8*b +: 8] = m_wd[8*b +: 8];
                m_b    = 1'b1;
                m_aw_p = 1'b0;
                m_w_p  = 1'b0;
            end else if (m_b && i_axi_bready) begin
                m_b = 1'b0;
            end
            if (aw_took) begin
                m_aw_p   = 1'b1;
                m_aw_idx = i_axi_awaddr[3:2];
            end
            if (w_took) begin
                m_w_p = 1'b1;
                m_wd  = i_axi_wdata;
                m_ws  = i_axi_wstrb;
            end
        end
    end

    // Cycle-by-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("awready", 32'(o_axi_awready), 32'(!m_aw_p));
            chk("wready",  32'(o_axi_wready),  32'(!m_w_p));
            chk("arready", 32'(o_axi_arready), 32'(m_rq.size() < 2));
            chk("bvalid",  32'(o_axi_bvalid),  32'(m_b));
            chk("rvalid",  32'(o_axi_rvalid),  32'(m_rq.size() > 0));
            chk("bresp",   32'(o_axi_bresp),   32'h0);
            chk("rresp",   32'(o_axi_rresp),   32'h0);
            if (m_rq.size() > 0) chk("rdata", o_axi_rdata, m_rq[0]);
        end
    end

    // ------------------------------------------------------------------
    // Directed sequences with literal expectations
    // ------------------------------------------------------------------
    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        @(posedge clk); #1;
        i_axi_awaddr = a; i_axi_awvalid = 1'b1;
        i_axi_wdata = d; i_axi_wstrb = s; i_axi_wvalid = 1'b1;
        i_axi_bready = 1'b1;
        @(posedge clk); #1;
        i_axi_awvalid = 1'b0; i_axi_wvalid = 1'b0;
        chk("wr_b_not_yet", 32'(o_axi_bvalid), 32'h0);
        @(posedge clk); #1;
        chk("wr_bvalid", 32'(o_axi_bvalid), 32'h1);
        chk("wr_bresp", 32'(o_axi_bresp), 32'h0);
        @(posedge clk); #1;
        chk("wr_b_done", 32'(o_axi_bvalid), 32'h0);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [31:0] exp);
        @(posedge clk); #1;
        i_axi_araddr = a; i_axi_arvalid = 1'b1; i_axi_rready = 1'b1;
        @(posedge clk); #1;
        i_axi_arvalid = 1'b0;
        chk("rd_rvalid", 32'(o_axi_rvalid), 32'h1);
        chk("rd_rdata", o_axi_rdata, exp);
        chk("rd_rresp", 32'(o_axi_rresp), 32'h0);
        @(posedge clk); #1;
        chk("rd_done", 32'(o_axi_rvalid), 32'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        i_axi_awaddr = '0; i_axi_awvalid = 1'b0;
        i_axi_wdata = '0; i_axi_wstrb = '0; i_axi_wvalid = 1'b0;
        i_axi_bready = 1'b0;
        i_axi_araddr = '0; i_axi_arvalid = 1'b0; i_axi_rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        rst_n  = 1'b1;
        // Reset state
        chk("rst_awready", 32'(o_axi_awready), 32'h1);
        chk("rst_wready",  32'(o_axi_wready),  32'h1);
        chk("rst_arready", 32'(o_axi_arready), 32'h1);
        chk("rst_bvalid",  32'(o_axi_bvalid),  32'h0);
        chk("rst_rvalid",  32'(o_axi_rvalid),  32'h0);
        chk("rst_rdata",   o_axi_rdata,        32'h0);

        // Full write then read back
        do_write(4'h4, 32'hDEADBEEF, 4'hF);
        do_read(4'h4, 32'hDEADBEEF);

        // Partial strobe merge
        do_write(4'h0, 32'h11223344, 4'hF);
        do_write(4'h0, 32'hAABBCCDD, 4'b0101);
        do_read(4'h0, 32'h11BB33DD);

        // Five back-to-back reads at full rate
        @(posedge clk); #1;
        i_axi_araddr = 4'h0; i_axi_arvalid = 1'b1; i_axi_rready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("b2b_rvalid", 32'(o_axi_rvalid), 32'h1);
            chk("b2b_arready", 32'(o_axi_arready), 32'h1);
            chk("b2b_rdata", o_axi_rdata, (i % 2 == 0) ? 32'h11BB33DD : 32'hDEADBEEF);
            i_axi_araddr = ((i + 1) % 2 == 1) ? 4'h4 : 4'h0;
            if (i == 4) i_axi_arvalid = 1'b0;
        end
        @(posedge clk); #1;
        chk("b2b_drained", 32'(o_axi_rvalid), 32'h0);

        // Read backpressure: two accepted, third blocked
        i_axi_rready = 1'b0;
        i_axi_araddr = 4'h4; i_axi_arvalid = 1'b1;
        @(posedge clk); #1;
        chk("bp_arready1", 32'(o_axi_arready), 32'h1);
        i_axi_araddr = 4'h0;
        @(posedge clk); #1;
        i_axi_arvalid = 1'b0;
        chk("bp_arready2", 32'(o_axi_arready), 32'h0);
        chk("bp_rdata0", o_axi_rdata, 32'hDEADBEEF);
        repeat (2) begin
            @(posedge clk); #1;
            chk("bp_stall_rvalid", 32'(o_axi_rvalid), 32'h1);
            chk("bp_stall_rdata", o_axi_rdata, 32'hDEADBEEF);
            chk("bp_stall_arready", 32'(o_axi_arready), 32'h0);
        end
        i_axi_rready = 1'b1;
        @(posedge clk); #1;
        chk("bp_rdata1", o_axi_rdata, 32'h11BB33DD);
        chk("bp_rvalid1", 32'(o_axi_rvalid), 32'h1);
        chk("bp_arready_back", 32'(o_axi_arready), 32'h1);
        @(posedge clk); #1;
        chk("bp_drained", 32'(o_axi_rvalid), 32'h0);

        // Split AW / W with B backpressure
        i_axi_bready = 1'b0;
        i_axi_awaddr = 4'h8; i_axi_awvalid = 1'b1;
        @(posedge clk); #1;
        i_axi_awvalid = 1'b0;
        chk("split_awready", 32'(o_axi_awready), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        i_axi_wdata = 32'hCAFEF00D; i_axi_wstrb = 4'hF; i_axi_wvalid = 1'b1;
        @(posedge clk); #1;
        i_axi_wvalid = 1'b0;
        chk("split_b_not_yet", 32'(o_axi_bvalid), 32'h0);
        chk("split_wready", 32'(o_axi_wready), 32'h0);
        @(posedge clk); #1;
        chk("split_bvalid", 32'(o_axi_bvalid), 32'h1);
        chk("split_bresp", 32'(o_axi_bresp), 32'h0);
        chk("split_awready_free", 32'(o_axi_awready), 32'h1);
        chk("split_wready_free", 32'(o_axi_wready), 32'h1);
        i_axi_awaddr = 4'hC; i_axi_awvalid = 1'b1;
        i_axi_wdata = 32'h12345678; i_axi_wvalid = 1'b1;
        @(posedge clk); #1;
        chk("lim_awready", 32'(o_axi_awready), 32'h0);
        chk("lim_wready", 32'(o_axi_wready), 32'h0);
        @(posedge clk); #1;
        chk("lim_awready2", 32'(o_axi_awready), 32'h0);
        chk("lim_wready2", 32'(o_axi_wready), 32'h0);
        chk("lim_bvalid_held", 32'(o_axi_bvalid), 32'h1);
        i_axi_awvalid = 1'b0; i_axi_wvalid = 1'b0;
        i_axi_bready = 1'b1;
        @(posedge clk); #1;
        chk("lim_second_b", 32'(o_axi_bvalid), 32'h1);
        @(posedge clk); #1;
        chk("lim_b_done", 32'(o_axi_bvalid), 32'h0);
        do_read(4'h8, 32'hCAFEF00D);
        do_read(4'hC, 32'h12345678);

        // Reset while both responses are pending
        i_axi_rready = 1'b0; i_axi_bready = 1'b0;
        @(posedge clk); #1;
        i_axi_araddr = 4'h4; i_axi_arvalid = 1'b1;
        i_axi_awaddr = 4'h4; i_axi_awvalid = 1'b1;
        i_axi_wdata = 32'h55555555; i_axi_wstrb = 4'hF; i_axi_wvalid = 1'b1;
        @(posedge clk); #1;
        i_axi_arvalid = 1'b0; i_axi_awvalid = 1'b0; i_axi_wvalid = 1'b0;
        chk("mr_rvalid", 32'(o_axi_rvalid), 32'h1);
        @(posedge clk); #1;
        chk("mr_bvalid", 32'(o_axi_bvalid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mr_rvalid0", 32'(o_axi_rvalid), 32'h0);
        chk("mr_bvalid0", 32'(o_axi_bvalid), 32'h0);
        chk("mr_awready1", 32'(o_axi_awready), 32'h1);
        chk("mr_wready1", 32'(o_axi_wready), 32'h1);
        chk("mr_arready1", 32'(o_axi_arready), 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_read(4'h4, 32'h0);
        do_read(4'h8, 32'h0);
        do_read(4'h0, 32'h0);

        // Randomized traffic, including one reset pulse mid-stream
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (c == 1500) rst_n = 1'b0;
            if (c == 1503) rst_n = 1'b1;
            if (!i_axi_awvalid || aw_took) begin
                i_axi_awvalid = ($urandom_range(0, 2) != 0);
                i_axi_awaddr  = 4'($urandom_range(0, 15));
            end
            if (!i_axi_wvalid || w_took) begin
                i_axi_wvalid = ($urandom_range(0, 2) != 0);
                i_axi_wdata  = $urandom;
                i_axi_wstrb  = 4'($urandom_range(0, 15));
            end
            if (!i_axi_arvalid || ar_took) begin
                i_axi_arvalid = ($urandom_range(0, 2) != 0);
                i_axi_araddr  = 4'($urandom_range(0, 15));
            end
            i_axi_bready = ($urandom_range(0, 3) != 0);
            i_axi_rready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        i_axi_awvalid = 1'b0; i_axi_wvalid = 1'b0; i_axi_arvalid = 1'b0;
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
